shift_reg_n: RTL and testbench
==============================

SHIFT_REG_N -- requirements
Module: shift_reg_n

Interface
REQ-001 Parameter: WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 Parameter: RESET_VAL, default 0, WIDTH-bit value loaded into q on reset.
REQ-003 Derived localparam: AMT_W = $clog2(WIDTH)+1, width of the shift-amount field.
REQ-004 Clock and reset ports, in this order:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-005 Remaining ports:
- clk_en  in  1  clock enable; when low, all state except done is frozen.
- start  in  1  operation request, sampled only in IDLE with clk_en=1.
- op  in  3  operation code: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR.
- amt  in  AMT_W  step count for ops 2-6.
- d  in  WIDTH  parallel load data.
- sin  in  1  serial fill bit for SHL and SHR.
- q  out  WIDTH  register contents.
- sout  out  1  last bit shifted or rotated out.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle completion pulse.

Function
REQ-006 FSM states: IDLE and SHIFT; busy SHALL equal (state==SHIFT).
REQ-007 IDLE with clk_en=1 and start=1 SHALL capture op and amt at that edge.
REQ-008 HOLD, LOAD and CLR SHALL complete in IDLE; done SHALL be high the next cycle.
- HOLD: q unchanged.
- LOAD: q<=d.
- CLR: q<=0.
REQ-009 Ops 2-6 with amt=0 SHALL leave q and sout unchanged and pulse done the next cycle.
REQ-010 Ops 2-6 with amt>0 SHALL enter SHIFT with an internal counter equal to amt.
REQ-011 In SHIFT, each clk_en=1 edge SHALL perform exactly one 1-bit step and decrement the counter.
REQ-012 The step that brings the counter to 0 SHALL return the FSM to IDLE; done SHALL be high the following cycle.
REQ-013 Step definitions:
- SHL: q<={q[W-2:0],sin}, sout<=q[W-1].
- SHR: q<={sin,q[W-1:1]}, sout<=q[0].
- ROL: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
- ROR: q<={q[0],q[W-1:1]}, sout<=q[0].
- ASR: q<={q[W-1],q[W-1:1]}, sout<=q[0].
REQ-014 sin SHALL be sampled on every step; changing sin mid-operation is legal.
REQ-015 amt values above WIDTH SHALL execute exactly amt steps, with no clamping.
REQ-016 clk_en=0 in SHIFT SHALL freeze q, sout, the counter and the state; completion is delayed one cycle per disabled cycle.
REQ-017 start while busy=1 SHALL be ignored; op, amt and d are don't-care during SHIFT.
REQ-018 done SHALL be a registered pulse exactly one clk cycle wide, deasserting regardless of clk_en.
REQ-019 done SHALL never assert while busy=1.
REQ-020 sout SHALL change only on shift/rotate steps; LOAD, CLR and HOLD leave it unchanged.

Reset
REQ-021 rst_n=0 SHALL immediately, without waiting for clk, force: q=RESET_VAL, sout=0, busy=0, done=0, counter=0, state=IDLE.
REQ-022 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse follows.
REQ-023 The first start after rst_n deasserts SHALL be accepted on the next enabled edge.

Verification
REQ-024 Bench SHALL cover these directed scenarios (WIDTH=8):
- Reset: RESET_VAL=8'hA5, assert rst_n low mid-SHIFT between edges -> q=8'hA5, busy=0, done=0 immediately; no later done pulse.
- LOAD: d=8'h3C, op=1 -> q=8'h3C after one edge; done high one cycle; busy never high.
- SHL: q=8'h81, op=2, amt=3, sin=1 -> busy high for 3 cycles; q=8'h0F, sout=0; then one-cycle done.
- ASR: q=8'h90, op=6, amt=2 -> q=8'hE4, sout=0.
- ROR with enable gaps: q=8'h5A, op=5, amt=8, clk_en low for 2 cycles mid-operation -> busy high for 10 cycles; final q=8'h5A, sout=0.
- Zero amount and ignored start: op=2, amt=0 -> q unchanged, done only; start during busy -> no effect on q or on the step count.

Source files
------------

// File: rtl/shift_reg_n.sv
// shift_reg_n: multi-mode shift/rotate register with a step-per-cycle
// sequencer, clock enable and a one-cycle completion pulse.
module shift_reg_n #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_q;
    logic             step_sout;
    op_e              op_in;

    assign op_in = op_e'(op);

    // One 1-bit step of the latched operation applied to the current contents
    always_comb begin
        step_q    = q_q;
        step_sout = sout_q;
        unique case (op_q)
            OP_SHL: begin
                step_q    = {q_q[WIDTH-2:0], sin};
                step_sout = q_q[WIDTH-1];
            end
            OP_SHR: begin
                step_q    = {sin, q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            OP_ROL: begin
                step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                step_sout = q_q[WIDTH-1];
            end
            OP_ROR: begin
                step_q    = {q_q[0], q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            OP_ASR: begin
                step_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                step_sout = q_q[0];
            end
            default: begin
                step_q    = q_q;
                step_sout = sout_q;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (clk_en && start) begin
                    op_d = op_in;
                    unique case (op_in)
                        OP_HOLD: done_d = 1'b1;
                        OP_LOAD: begin
                            q_d    = d;
                            done_d = 1'b1;
                        end
                        OP_CLR: begin
                            q_d    = '0;
                            done_d = 1'b1;
                        end
                        default: begin
                            if (amt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = ST_SHIFT;
                                cnt_d   = amt;
                            end
                        end
                    endcase
                end
            end
            ST_SHIFT: begin
                if (clk_en) begin
                    q_d    = step_q;
                    sout_d = step_sout;
                    cnt_d  = cnt_q - AMT_W'(1);
                    if (cnt_q == AMT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // done_q is not gated by clk_en so the pulse always lasts one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            q_q     <= RESET_VAL;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign sout = sout_q;
    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;

endmodule

// File: tb/tb_shift_reg_n.sv
// tb_shift_reg_n: directed and random checks of shift_reg_n against
// an arithmetic reference model.
module tb_shift_reg_n;

    localparam int W     = 8;
    localparam int AMT_W = $clog2(W) + 1;

    logic             clk;
    logic             rst_n;
    logic             clk_en;
    logic             start;
    logic [2:0]       op;
    logic [AMT_W-1:0] amt;
    logic [W-1:0]     d;
    logic             sin;
    logic [W-1:0]     q;
    logic             sout;
    logic             busy;
    logic             done;

    int n_tests;
    int n_fail;

    int mq, msout, mrem, mop;
    bit mbusy, mdone;

    shift_reg_n #(
        .WIDTH(W),
        .RESET_VAL(8'hA5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clk_en(clk_en),
        .start(start),
        .op(op),
        .amt(amt),
        .d(d),
        .sin(sin),
        .q(q),
        .sout(sout),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq    = 'hA5;
        msout = 0;
        mrem  = 0;
        mop   = 0;
        mbusy = 0;
        mdone = 0;
    endtask

    // Reference: one step is plain arithmetic on an integer of W bits
    task automatic model_step();
        int top, bot;
        top = mq / 128;
        bot = mq % 2;
        case (mop)
            2: begin msout = top; mq = (mq * 2) % 256 + sin; end
            3: begin msout = bot; mq = mq / 2 + sin * 128; end
            4: begin msout = top; mq = (mq * 2) % 256 + top; end
            5: begin msout = bot; mq = mq / 2 + bot * 128; end
            6: begin msout = bot; mq = mq / 2 + top * 128; end
            default: ;
        endcase
    endtask

    task automatic model_edge();
        bit nd;
        nd = 0;
        if (!mbusy) begin
            if (clk_en && start) begin
                case (int'(op))
                    0: nd = 1;
                    1: begin mq = int'(d); nd = 1; end
                    7: begin mq = 0; nd = 1; end
                    default: begin
                        if (amt == 0) nd = 1;
                        else begin
                            mbusy = 1;
                            mrem  = int'(amt);
                            mop   = int'(op);
                        end
                    end
                endcase
            end
        end else if (clk_en) begin
            model_step();
            mrem--;
            if (mrem == 0) begin
                mbusy = 0;
                nd    = 1;
            end
        end
        mdone = nd;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check("q", 32'(q), 32'(mq));
        check("sout", 32'(sout), 32'(msout));
        check("busy", 32'(busy), 32'(mbusy));
        check("done", 32'(done), 32'(mdone));
    endtask

    task automatic run_op(input int o, input int a, input int dv,
                          input bit s, input bit keep_start,
                          input int gap_at,
                          output int bcnt, output int dcnt);
        int i;
        bcnt   = 0;
        dcnt   = 0;
        clk_en = 1'b1;
        start  = 1'b1;
        op     = 3'(o);
        amt    = AMT_W'(a);
        d      = W'(dv);
        sin    = s;
        tick();
        if (busy) bcnt++;
        if (done) dcnt++;
        i = 0;
        while ((mbusy || mdone) && i < 40) begin
            start  = keep_start && mbusy;
            if (keep_start) begin
                op  = 3'd1;
                d   = 8'hFF;
                amt = AMT_W'(1);
            end
            clk_en = !(i >= gap_at && i < gap_at + 2);
            tick();
            if (busy) bcnt++;
            if (done) dcnt++;
            i++;
        end
        start  = 1'b0;
        clk_en = 1'b1;
        if (i >= 40) check("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int bc, dc;
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst_n  = 1'b0;
        clk_en = 1'b0;
        start  = 1'b0;
        op     = '0;
        amt    = '0;
        d      = '0;
        sin    = 1'b0;
        tick();
        check("rst_q", 32'(q), 32'h A5);
        tick();
        rst_n = 1'b1;

        run_op(1, 0, 'h3C, 0, 0, 100, bc, dc);
        check("load_q", 32'(q), 32'h3C);
        check("load_busy", 32'(bc), 32'd0);
        check("load_done", 32'(dc), 32'd1);

        run_op(1, 0, 'h81, 0, 0, 100, bc, dc);
        run_op(2, 3, 0, 1, 0, 100, bc, dc);
        check("shl_q", 32'(q), 32'h0F);
        check("shl_sout", 32'(sout), 32'd0);
        check("shl_busy", 32'(bc), 32'd3);
        check("shl_done", 32'(dc), 32'd1);

        run_op(1, 0, 'h90, 0, 0, 100, bc, dc);
        run_op(6, 2, 0, 0, 0, 100, bc, dc);
        check("asr_q", 32'(q), 32'hE4);
        check("asr_sout", 32'(sout), 32'd0);

        run_op(1, 0, 'h5A, 0, 0, 100, bc, dc);
        run_op(5, 8, 0, 0, 0, 3, bc, dc);
        check("ror_q", 32'(q), 32'h5A);
        check("ror_sout", 32'(sout), 32'd0);
        check("ror_busy", 32'(bc), 32'd10);

        run_op(1, 0, 'hA5, 0, 0, 100, bc, dc);
        run_op(2, 1, 0, 0, 0, 100, bc, dc);
        check("shl1_q", 32'(q), 32'h4A);
        check("shl1_sout", 32'(sout), 32'd1);
        run_op(2, 0, 0, 1, 0, 100, bc, dc);
        check("zero_q", 32'(q), 32'h4A);
        check("zero_sout", 32'(sout), 32'd1);
        check("zero_busy", 32'(bc), 32'd0);
        check("zero_done", 32'(dc), 32'd1);

        run_op(1, 0, 'h81, 0, 0, 100, bc, dc);
        run_op(2, 3, 0, 1, 1, 100, bc, dc);
        check("ign_q", 32'(q), 32'h0F);
        check("ign_busy", 32'(bc), 32'd3);

        clk_en = 1'b1;
        start  = 1'b1;
        op     = 3'd4;
        amt    = AMT_W'(8);
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", 32'(q), 32'hA5);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        model_reset();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();

        for (int i = 0; i < 600; i++) begin
            clk_en = ($urandom_range(0, 7) != 0);
            start  = ($urandom_range(0, 2) != 0);
            op     = 3'($urandom_range(0, 7));
            amt    = AMT_W'($urandom_range(0, 15));
            d      = W'($urandom);
            sin    = 1'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
